icache: RTL and testbench



---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_array.sv | 58 +++++
 rtl/icache.sv | 135 +++++++++++++
 tb/tb_icache.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared types and constants for the direct-mapped instruction cache:
//   ADDR_TYPE / INST_TYPE  - 32-bit address and instruction words
//   TRUE / FALSE           - single-bit flag constants
//   INST_RESET             - value of the instruction output after reset
//   ICACHE_INDEX_BITS      - default log2 of the line count
//   state_t                - controller states (IDLE, MISS, DRAIN)
// ---------------------------------------------------------------------------
package icache_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  localparam logic     TRUE       = 1'b1;
  localparam logic     FALSE      = 1'b0;
  localparam INST_TYPE INST_RESET = 32'h0000_0000;

  localparam int ICACHE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // accepting fetches
    MISS  = 2'd1,  // waiting for the fill word, reply goes to the fetcher
    DRAIN = 2'd2   // flushed while waiting; fill the line, discard the reply
  } state_t;

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk_in, rst_in      - clock, synchronous active-high reset (clears valid)
//   rd_index            - combinational read port index
//   rd_valid/tag/data   - contents of the addressed line
//   we                  - write enable (caller already qualifies it with rdy)
//   wr_index/tag/data   - line written on the rising edge when we=1
// ---------------------------------------------------------------------------
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 32 - 2 - ICACHE_INDEX_BITS
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output INST_TYPE              rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  INST_TYPE              wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  INST_TYPE            data_mem [LINES];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= TRUE;
    end
  end

  // NOTE: only the valid bits are reset; tag/data contents are meaningless
  // until their valid bit is set, and a reset would stop RAM inference.
  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache, one 32-bit instruction per line, between
// the instruction fetcher and the memory controller.
// Ports:
//   clk_in, rst_in           - clock, synchronous active-high reset
//   rdy_in                   - global enable; low freezes all state
//   clear_in                 - pipeline flush; drops/suppresses pending reply
//   fetch_valid_in/pc_in     - fetch request (pc bits [1:0] ignored)
//   inst_valid_out, inst_out - one-cycle reply pulse and instruction
//   busy_out                 - miss outstanding; fetch requests are ignored
//   mem_enable_out/addr_out  - word-read request to the memory controller
//   mem_done_in/data_in      - read completion pulse and data
// ---------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_in,
  input  logic     fetch_valid_in,
  input  ADDR_TYPE fetch_pc_in,
  output logic     inst_valid_out,
  output INST_TYPE inst_out,
  output logic     busy_out,
  output logic     mem_enable_out,
  output ADDR_TYPE mem_addr_out,
  input  logic     mem_done_in,
  input  INST_TYPE mem_data_in
);

  localparam int TAG_BITS = 32 - 2 - INDEX_BITS;

  state_t state;

  logic [INDEX_BITS-1:0] fetch_index;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  ADDR_TYPE              fetch_addr;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  INST_TYPE              rd_data;
  logic                  hit;
  logic                  fill_we;

  assign fetch_addr  = fetch_pc_in & ~ADDR_TYPE'(3);
  assign fetch_index = fetch_addr[INDEX_BITS+1:2];
  assign fetch_tag   = fetch_addr[31:INDEX_BITS+2];

  // The outstanding miss address is held in mem_addr_out, so the fill
  // location is taken from there rather than from a separate pc latch.
  assign fill_index  = mem_addr_out[INDEX_BITS+1:2];
  assign fill_tag    = mem_addr_out[31:INDEX_BITS+2];

  assign hit = rd_valid && (rd_tag == fetch_tag);

  // The line is filled on completion in both MISS and DRAIN: a flushed
  // request still brings back a correct instruction worth keeping.
  assign fill_we = rdy_in && !rst_in && mem_done_in &&
                   ((state == MISS) || (state == DRAIN));

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (fetch_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_data  (mem_data_in)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      inst_valid_out <= FALSE;
      inst_out       <= INST_RESET;
      busy_out       <= FALSE;
      mem_enable_out <= FALSE;
      mem_addr_out   <= '0;
    end else if (rdy_in) begin
      inst_valid_out <= FALSE;
      case (state)
        IDLE: begin
          if (fetch_valid_in && !clear_in) begin
            if (hit) begin
              inst_valid_out <= TRUE;
              inst_out       <= rd_data;
            end else begin
              mem_enable_out <= TRUE;
              mem_addr_out   <= fetch_addr;
              busy_out       <= TRUE;
              state          <= MISS;
            end
          end
        end
        MISS: begin
          if (mem_done_in) begin
            mem_enable_out <= FALSE;
            busy_out       <= FALSE;
            state          <= IDLE;
            if (!clear_in) begin
              inst_valid_out <= TRUE;
              inst_out       <= mem_data_in;
            end
          end else if (clear_in) begin
            // The controller cannot abort a word read; keep the request up.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_done_in) begin
            mem_enable_out <= FALSE;
            busy_out       <= FALSE;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
// Directed bench for icache: a table of fetch vectors (pc, hit/miss, word)
// walked in order against a known cache history, followed by hand-written
// sequences for back-to-back hits, flushes, stalls and reset.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        fetch_valid_in;
  logic [31:0] fetch_pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic        busy_out;
  logic        mem_enable_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;

  int checks = 0;
  int errors = 0;

  icache dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .fetch_valid_in (fetch_valid_in),
    .fetch_pc_in    (fetch_pc_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .busy_out       (busy_out),
    .mem_enable_out (mem_enable_out),
    .mem_addr_out   (mem_addr_out),
    .mem_done_in    (mem_done_in),
    .mem_data_in    (mem_data_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic        miss;
    logic [31:0] word;
  } vec_t;

  localparam logic [31:0] W_A = 32'h00A0_0093;
  localparam logic [31:0] W_B = 32'h00B0_0113;
  localparam logic [31:0] W_C = 32'hDEAD_BEEF;
  localparam logic [31:0] W_D = 32'hCAFE_F00D;
  localparam logic [31:0] W_E = 32'h1122_3344;
  localparam logic [31:0] W_F = 32'h0000_0013;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input logic v, input logic b, input logic me);
    check({name, " inst_valid"}, 32'(inst_valid_out), 32'(v));
    check({name, " busy"},       32'(busy_out),       32'(b));
    check({name, " mem_enable"}, 32'(mem_enable_out), 32'(me));
  endtask

  task automatic mem_reply(input logic [31:0] data);
    mem_done_in = 1'b1;
    mem_data_in = data;
    @(negedge clk_in);
    mem_done_in = 1'b0;
    mem_data_in = 32'h0;
  endtask

  // One complete fetch: request, optional memory round trip, reply pulse,
  // and a check that the pulse lasts exactly one cycle.
  task automatic do_fetch(input string name, input logic [31:0] pc,
                          input logic miss, input logic [31:0] word);
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    if (miss) begin
      check_ctl({name, " req"}, 1'b0, 1'b1, 1'b1);
      check({name, " mem_addr"}, mem_addr_out, pc & 32'hFFFF_FFFC);
      @(negedge clk_in);
      check_ctl({name, " hold"}, 1'b0, 1'b1, 1'b1);
      mem_reply(word);
    end
    check_ctl({name, " reply"}, 1'b1, 1'b0, 1'b0);
    check({name, " inst"}, inst_out, word);
    @(negedge clk_in);
    check({name, " pulse end"}, 32'(inst_valid_out), 32'h0);
  endtask

  vec_t vecs [15];

  initial begin
    // Expected contents follow the fill history: index = pc[7:2], tag = pc[31:8].
    vecs[0]  = '{32'h0000_0004, 1'b1, W_A};  // cold miss
    vecs[1]  = '{32'h0000_0004, 1'b0, W_A};  // hit
    vecs[2]  = '{32'h0000_0008, 1'b1, W_B};
    vecs[3]  = '{32'h0000_0104, 1'b1, W_C};  // conflict on line 1
    vecs[4]  = '{32'h0000_0004, 1'b1, W_A};  // evicted, misses again
    vecs[5]  = '{32'h0000_0106, 1'b1, W_C};  // low bits ignored
    vecs[6]  = '{32'h0000_0107, 1'b0, W_C};
    vecs[7]  = '{32'h0000_00FC, 1'b1, W_D};  // last line
    vecs[8]  = '{32'h0000_00FC, 1'b0, W_D};
    vecs[9]  = '{32'hFFFF_FFFC, 1'b1, W_E};  // all-ones tag, last line
    vecs[10] = '{32'h0000_0008, 1'b0, W_B};
    vecs[11] = '{32'h0000_00FC, 1'b1, W_D};
    vecs[12] = '{32'hFFFF_FFFC, 1'b1, W_E};
    vecs[13] = '{32'h0000_0000, 1'b1, W_F};  // line 0
    vecs[14] = '{32'h0000_0000, 1'b0, W_F};

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    fetch_valid_in = 1'b0; fetch_pc_in = 32'h0;
    mem_done_in = 1'b0; mem_data_in = 32'h0;
    repeat (2) @(negedge clk_in);
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check("reset inst", inst_out, 32'h0);
    check("reset mem_addr", mem_addr_out, 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);

    for (int i = 0; i < 15; i++)
      do_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].miss, vecs[i].word);

    // Back-to-back hits: one pulse per cycle.
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0104;
    @(negedge clk_in);
    check_ctl("b2b 1", 1'b1, 1'b0, 1'b0); check("b2b 1 inst", inst_out, W_C);
    fetch_pc_in = 32'h0000_0008;
    @(negedge clk_in);
    check_ctl("b2b 2", 1'b1, 1'b0, 1'b0); check("b2b 2 inst", inst_out, W_B);
    fetch_pc_in = 32'hFFFF_FFFC;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    check_ctl("b2b 3", 1'b1, 1'b0, 1'b0); check("b2b 3 inst", inst_out, W_E);
    @(negedge clk_in);
    check_ctl("b2b end", 1'b0, 1'b0, 1'b0);

    // Completion pulse while idle is ignored and corrupts nothing.
    mem_reply(32'hBAD0_BAD0);
    check_ctl("idle done", 1'b0, 1'b0, 1'b0);
    do_fetch("idle done hit", 32'h0000_0008, 1'b0, W_B);

    // Flush in IDLE drops both a hit and a miss request.
    fetch_valid_in = 1'b1; clear_in = 1'b1; fetch_pc_in = 32'h0000_0008;
    @(negedge clk_in);
    check_ctl("clr idle hit", 1'b0, 1'b0, 1'b0);
    fetch_pc_in = 32'h0000_0030;
    @(negedge clk_in);
    fetch_valid_in = 1'b0; clear_in = 1'b0;
    check_ctl("clr idle miss", 1'b0, 1'b0, 1'b0);

    // Flush two cycles into a miss: request held, reply discarded, line filled.
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0010;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    check_ctl("drain req", 1'b0, 1'b1, 1'b1);
    @(negedge clk_in);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_ctl($sformatf("drain hold%0d", i), 1'b0, 1'b1, 1'b1);
      check("drain addr", mem_addr_out, 32'h0000_0010);
      @(negedge clk_in);
    end
    mem_reply(32'h1234_5678);
    check_ctl("drain done", 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    check_ctl("drain after", 1'b0, 1'b0, 1'b0);
    do_fetch("drain refetch", 32'h0000_0010, 1'b0, 32'h1234_5678);

    // Flush in the same cycle as completion.
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0020;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    clear_in = 1'b1;
    mem_reply(32'h55AA_55AA);
    clear_in = 1'b0;
    check_ctl("clr+done", 1'b0, 1'b0, 1'b0);
    do_fetch("clr+done refetch", 32'h0000_0020, 1'b0, 32'h55AA_55AA);

    // Stall holds a reply pulse in place.
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0008;
    @(negedge clk_in);
    fetch_valid_in = 1'b0; rdy_in = 1'b0;
    @(negedge clk_in);
    check_ctl("stall pulse", 1'b1, 1'b0, 1'b0);
    rdy_in = 1'b1;
    @(negedge clk_in);
    check_ctl("stall pulse end", 1'b0, 1'b0, 1'b0);

    // Stall during MISS: a completion seen while stalled is not taken.
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0040;
    @(negedge clk_in);
    fetch_valid_in = 1'b0; rdy_in = 1'b0;
    mem_done_in = 1'b1; mem_data_in = 32'hBADB_AD00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check_ctl($sformatf("stall miss%0d", i), 1'b0, 1'b1, 1'b1);
      check("stall addr", mem_addr_out, 32'h0000_0040);
    end
    rdy_in = 1'b1; mem_done_in = 1'b0; mem_data_in = 32'h0;
    @(negedge clk_in);
    check_ctl("stall resume", 1'b0, 1'b1, 1'b1);
    mem_reply(32'h4040_4040);
    check_ctl("stall done", 1'b1, 1'b0, 1'b0);
    check("stall inst", inst_out, 32'h4040_4040);
    @(negedge clk_in);
    do_fetch("stall refetch", 32'h0000_0040, 1'b0, 32'h4040_4040);

    // Reset mid-MISS clears outputs and all valid bits.
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0050;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    check_ctl("pre reset", 1'b0, 1'b1, 1'b1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_ctl("mid reset", 1'b0, 1'b0, 1'b0);
    check("mid reset inst", inst_out, 32'h0);
    check("mid reset addr", mem_addr_out, 32'h0);
    do_fetch("post reset", 32'h0000_0008, 1'b1, W_B);
    do_fetch("post reset hit", 32'h0000_0008, 1'b0, W_B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
